// File: rtl/keyboard_controller.sv
// PS/2 receive controller: synchronised oversampling, frame FSM with parity/stop/timeout checks,
// E0/F0 prefix decode and per-action held/pulse state. Define KB_WASD_EN to add W/A/D as movement sources.
module keyboard_controller #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       kb_clock,
    input  logic       kb_data,
    output logic [8:0] scan_code,
    output logic       scan_break,
    output logic       scan_valid,
    output logic [4:0] key_held,
    output logic [4:0] key_pulse,
    output logic       frame_error
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    function automatic logic [4:0] f_arrow_map(input logic [8:0] code);
        case (code)
            9'h175:  return 5'b00001;
            9'h172:  return 5'b00010;
            9'h16B:  return 5'b00100;
            9'h174:  return 5'b01000;
            9'h01B:  return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    logic [SYNC_STAGES-1:0] r_sync_clk;
    logic [SYNC_STAGES-1:0] r_sync_dat;
    logic                   r_clk_prev;
    logic                   r_fall;
    logic                   r_fall_data;
    state_t                 r_state;
    logic [2:0]             r_bitcnt;
    logic [7:0]             r_shreg;
    logic                   r_parity;
    logic                   r_ext;
    logic                   r_brk;
    logic [TO_W-1:0]        r_to_cnt;
    logic [4:0]             r_arrow_held;

    logic       w_sync_clk;
    logic       w_sync_dat;
    logic [8:0] w_code;
    logic       w_accept;
    logic [4:0] w_arrow_map;
    logic [4:0] w_arrow_n;
    logic [4:0] w_held_n;

    assign w_sync_clk  = r_sync_clk[SYNC_STAGES-1];
    assign w_sync_dat  = r_sync_dat[SYNC_STAGES-1];
    assign w_code      = {r_ext, r_shreg};
    // Stop bit is the sample in the current fall cycle; odd parity over data+parity.
    assign w_accept    = r_fall_data & (^{r_shreg, r_parity});
    assign w_arrow_map = f_arrow_map(w_code);
    assign w_arrow_n   = r_brk ? (r_arrow_held & ~w_arrow_map) : (r_arrow_held | w_arrow_map);

`ifdef KB_WASD_EN
    function automatic logic [4:0] f_letter_map(input logic [8:0] code);
        case (code)
            9'h01D:  return 5'b00001;
            9'h01C:  return 5'b00100;
            9'h023:  return 5'b01000;
            default: return 5'b00000;
        endcase
    endfunction

    logic [4:0] r_letter_held;
    logic [4:0] w_letter_map;
    logic [4:0] w_letter_n;

    assign w_letter_map = f_letter_map(w_code);
    assign w_letter_n   = r_brk ? (r_letter_held & ~w_letter_map) : (r_letter_held | w_letter_map);
    assign w_held_n     = w_arrow_n | w_letter_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_letter_held <= '0;
        end else if (r_fall && r_state == S_STOP && w_accept &&
                     r_shreg != 8'hE0 && r_shreg != 8'hF0) begin
            r_letter_held <= w_letter_n;
        end
    end
`else
    assign w_held_n = w_arrow_n;
`endif

    // Synchronisers idle high so reset never manufactures a falling edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync_clk  <= '1;
            r_sync_dat  <= '1;
            r_clk_prev  <= 1'b1;
            r_fall      <= 1'b0;
            r_fall_data <= 1'b1;
        end else begin
            r_sync_clk  <= {r_sync_clk[SYNC_STAGES-2:0], kb_clock};
            r_sync_dat  <= {r_sync_dat[SYNC_STAGES-2:0], kb_data};
            r_clk_prev  <= w_sync_clk;
            r_fall      <= r_clk_prev & ~w_sync_clk;
            r_fall_data <= w_sync_dat;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_bitcnt     <= '0;
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_to_cnt     <= '0;
            r_arrow_held <= '0;
            scan_code    <= '0;
            scan_break   <= 1'b0;
            scan_valid   <= 1'b0;
            key_held     <= '0;
            key_pulse    <= '0;
            frame_error  <= 1'b0;
        end else begin
            scan_valid  <= 1'b0;
            key_pulse   <= '0;
            frame_error <= 1'b0;
            if (r_fall) begin
                r_to_cnt <= '0;
                case (r_state)
                    S_IDLE: begin
                        if (!r_fall_data) begin
                            r_state  <= S_DATA;
                            r_bitcnt <= '0;
                        end
                    end
                    S_DATA: begin
                        r_shreg[r_bitcnt] <= r_fall_data;
                        r_bitcnt          <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_parity <= r_fall_data;
                        r_state  <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        if (!w_accept) begin
                            frame_error <= 1'b1;
                            r_ext       <= 1'b0;
                            r_brk       <= 1'b0;
                        end else if (r_shreg == 8'hE0) begin
                            r_ext <= 1'b1;
                        end else if (r_shreg == 8'hF0) begin
                            r_brk <= 1'b1;
                        end else begin
                            scan_code    <= w_code;
                            scan_break   <= r_brk;
                            scan_valid   <= 1'b1;
                            r_ext        <= 1'b0;
                            r_brk        <= 1'b0;
                            r_arrow_held <= w_arrow_n;
                            key_held     <= w_held_n;
                            key_pulse    <= w_held_n & ~key_held;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (r_state != S_IDLE) begin
                if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    r_state     <= S_IDLE;
                    r_to_cnt    <= '0;
                    frame_error <= 1'b1;
                    r_ext       <= 1'b0;
                    r_brk       <= 1'b0;
                end else begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_keyboard_controller.sv
// Directed bench for keyboard_controller: bit-level PS/2 frames with hand-computed expectations.
module tb_keyboard_controller;

    localparam int TO = 300;

    logic       clock = 1'b0;
    logic       reset;
    logic       kb_clock;
    logic       kb_data;
    logic [8:0] scan_code;
    logic       scan_break;
    logic       scan_valid;
    logic [4:0] key_held;
    logic [4:0] key_pulse;
    logic       frame_error;

    keyboard_controller #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .kb_clock    (kb_clock),
        .kb_data     (kb_data),
        .scan_code   (scan_code),
        .scan_break  (scan_break),
        .scan_valid  (scan_valid),
        .key_held    (key_held),
        .key_pulse   (key_pulse),
        .frame_error (frame_error)
    );

    always #5 clock = ~clock;

    int    n_checks = 0;
    int    n_errors = 0;
    int    sv_cnt = 0;
    int    fe_cnt = 0;
    int    kp_cnt [5] = '{0, 0, 0, 0, 0};
    logic [8:0] last_code = '0;
    logic  last_brk = 1'b0;
    longint t_drop = 0;
    longint t_sv = 0;
    longint t_fe = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (scan_valid === 1'b1) begin
            sv_cnt++;
            last_code = scan_code;
            last_brk  = scan_break;
            t_sv      = $time;
        end
        if (frame_error === 1'b1) begin
            fe_cnt++;
            t_fe = $time;
        end
        for (int i = 0; i < 5; i++)
            if (key_pulse[i] === 1'b1) kp_cnt[i]++;
    end

    task automatic send_bit(input logic b);
        @(negedge clock);
        kb_data = b;
        repeat (4) @(negedge clock);
        kb_clock = 1'b0;
        t_drop = $time;
        repeat (8) @(negedge clock);
        kb_clock = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(bad_par ? (^b) : ~(^b));
        send_bit(1'b1);
        repeat (10) @(negedge clock);
    endtask

    int sv0, fe0, kp0, kp4;

    initial begin
        kb_clock = 1'b1;
        kb_data  = 1'b1;
        reset    = 1'b1;
        repeat (3) @(negedge clock);
        check_eq("rst_code",  32'(scan_code), 32'h0);
        check_eq("rst_held",  32'(key_held), 32'h0);
        check_eq("rst_valid", 32'(scan_valid), 32'h0);
        check_eq("rst_ferr",  32'(frame_error), 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // E0 75: up make
        sv0 = sv_cnt;
        send_byte(8'hE0, 1'b0);
        check_eq("t1_prefix_no_valid", 32'(sv_cnt - sv0), 32'd0);
        send_byte(8'h75, 1'b0);
        check_eq("t1_valid_cnt", 32'(sv_cnt - sv0), 32'd1);
        check_eq("t1_code",      32'(last_code), 32'h175);
        check_eq("t1_brk",       32'(last_brk), 32'h0);
        check_eq("t1_held",      32'(key_held), 32'h01);
        check_eq("t1_pulse_up",  32'(kp_cnt[0]), 32'd1);
        check_eq("t1_latency",   32'(t_sv - t_drop), 32'd40);

        // E0 F0 75: up break
        sv0 = sv_cnt;
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        check_eq("t2_valid_cnt", 32'(sv_cnt - sv0), 32'd1);
        check_eq("t2_code",      32'(last_code), 32'h175);
        check_eq("t2_brk",       32'(last_brk), 32'h1);
        check_eq("t2_held",      32'(key_held), 32'h00);
        check_eq("t2_no_pulse",  32'(kp_cnt[0]), 32'd1);

        // 1B typematic x3
        sv0 = sv_cnt;
        for (int i = 0; i < 3; i++) send_byte(8'h1B, 1'b0);
        check_eq("t3_valid_cnt", 32'(sv_cnt - sv0), 32'd3);
        check_eq("t3_code",      32'(last_code), 32'h01B);
        check_eq("t3_held",      32'(key_held), 32'h10);
        check_eq("t3_pulse_once", 32'(kp_cnt[4]), 32'd1);

        // bad parity on 72, then good E0 72
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        send_byte(8'h72, 1'b1);
        check_eq("t4_ferr_cnt",  32'(fe_cnt - fe0), 32'd1);
        check_eq("t4_no_valid",  32'(sv_cnt - sv0), 32'd0);
        check_eq("t4_held_kept", 32'(key_held), 32'h10);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h72, 1'b0);
        check_eq("t4_code",      32'(last_code), 32'h172);
        check_eq("t4_held_down", 32'(key_held), 32'h12);

        // timeout after 4 data bits
        fe0 = fe_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        repeat (TO + 20) @(negedge clock);
        check_eq("t5_ferr_cnt",  32'(fe_cnt - fe0), 32'd1);
        check_eq("t5_ferr_time", 32'(t_fe - t_drop), 32'(10 * (TO + 4)));
        sv0 = sv_cnt;
        send_byte(8'h1B, 1'b0);
        check_eq("t5_valid_cnt", 32'(sv_cnt - sv0), 32'd1);
        check_eq("t5_code",      32'(last_code), 32'h01B);
        check_eq("t5_brk",       32'(last_brk), 32'h0);

        // hold up and left, reset mid-frame
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h6B, 1'b0);
        check_eq("t6_held_multi", 32'(key_held), 32'h17);
        send_bit(1'b0);
        send_bit(1'b1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_eq("t6_rst_held", 32'(key_held), 32'h0);
        check_eq("t6_rst_code", 32'(scan_code), 32'h0);
        check_eq("t6_rst_brk",  32'(scan_break), 32'h0);
        check_eq("t6_rst_ferr", 32'(frame_error), 32'h0);
        reset = 1'b0;
        @(negedge clock);
        sv0 = sv_cnt;
        send_byte(8'h1B, 1'b0);
        check_eq("t6_post_valid", 32'(sv_cnt - sv0), 32'd1);
        check_eq("t6_post_code",  32'(last_code), 32'h01B);
        check_eq("t6_post_held",  32'(key_held), 32'h10);

`ifdef KB_WASD_EN
        kp0 = kp_cnt[0];
        send_byte(8'h1D, 1'b0);
        check_eq("w_w_held",  32'(key_held), 32'h11);
        check_eq("w_w_pulse", 32'(kp_cnt[0] - kp0), 32'd1);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        check_eq("w_up_held",     32'(key_held), 32'h11);
        check_eq("w_up_no_pulse", 32'(kp_cnt[0] - kp0), 32'd1);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        check_eq("w_up_rel_held", 32'(key_held), 32'h11);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1D, 1'b0);
        check_eq("w_w_rel_held", 32'(key_held), 32'h10);
`else
        sv0 = sv_cnt;
        kp4 = kp_cnt[4];
        send_byte(8'h1D, 1'b0);
        check_eq("unmapped_valid", 32'(sv_cnt - sv0), 32'd1);
        check_eq("unmapped_code",  32'(last_code), 32'h01D);
        check_eq("unmapped_held",  32'(key_held), 32'h10);
        check_eq("unmapped_pulse", 32'(kp_cnt[4] - kp4), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keyboard_controller.md
Name: keyboard_controller

Overview:
Single-clock PS/2 receive controller for the game input path. It oversamples the raw PS/2 clock and data lines in the system clock domain and sequences bit capture through a frame FSM. It checks parity, stop bit and timeout, and decodes the E0 (extended) and F0 (break) prefixes. It keeps a held/pressed state per game action and feeds the player-movement and shoot logic directly, replacing free-running capture on the PS/2 clock edge.

Parameters:
TIMEOUT_CYCLES, 50000, system clocks without a PS/2 falling edge before an in-progress frame is aborted (1 ms at 50 MHz)
SYNC_STAGES, 2, flip-flop depth of the kb_clock/kb_data synchronisers (minimum 2)

Ports:
clock  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
kb_clock  input  1  raw PS/2 clock, asynchronous
kb_data  input  1  raw PS/2 data, asynchronous
scan_code  output  9  last decoded code: {extended, byte}
scan_break  output  1  1 if scan_code was a release (F0-prefixed)
scan_valid  output  1  one-cycle strobe; scan_code/scan_break updated on this cycle
key_held  output  5  level per action: [0] up, [1] down, [2] left, [3] right, [4] shoot
key_pulse  output  5  one-cycle strobe per action on a 0->1 transition of key_held
frame_error  output  1  one-cycle strobe on parity, start, stop or timeout error

Behaviour:
- Reset (dominates all other events):
  - All outputs 0; FSM to IDLE; bit counter 0; ext/brk flags 0; timeout counter 0.
  - Synchronisers are reset to 1 (idle bus).
- Edge detect: fall = sync_clk_prev & ~sync_clk, registered. Data is sampled from synchronised kb_data in the fall cycle.
- Frame FSM:
  - IDLE: on fall with data=0, go to DATA with bitcnt=0. On fall with data=1, stay in IDLE and raise no error (glitch/resync).
  - DATA: on each fall, shift data into shreg[bitcnt] (LSB first) and increment bitcnt. After the 8th bit, go to PARITY.
  - PARITY: on fall, capture the parity bit and go to STOP.
  - STOP: on fall, go to IDLE. Byte is accepted only if stop=1 and ^{shreg,parity}=1 (odd parity). Otherwise pulse frame_error and discard the byte.
- Timeout: the counter runs in any state except IDLE and clears on every fall. On reaching TIMEOUT_CYCLES-1: go to IDLE, pulse frame_error, clear ext/brk.
- Any frame error clears ext/brk. key_held is left unchanged.
- Byte decode, on the cycle after an accepted STOP fall:
  - E0: set ext; no scan_valid.
  - F0: set brk; no scan_valid.
  - Other: scan_code={ext,byte}, scan_break=brk, scan_valid=1; clear ext and brk.
- Latency: scan_valid asserts exactly 1 clock after the cycle in which the stop-bit fall is registered. key_held and key_pulse update on the same cycle as scan_valid.
- Key map (code -> bit):
  - 0x175 -> 0 (up)
  - 0x172 -> 1 (down)
  - 0x16B -> 2 (left)
  - 0x174 -> 3 (right)
  - 0x01B -> 4 (shoot)
  - Unmapped codes still produce scan_valid but change nothing else.
- Make sets the bit; break clears it. A repeated make (typematic) while held produces no further key_pulse.
- Break for a bit that is not held is a no-op.
- Multiple keys may be held simultaneously.
- At most one byte completes per frame, so simultaneous decode events cannot occur.

Optional Feature:
KB_WASD_EN
- Defined:
  - W (0x01D) is an additional source for up, A (0x01C) for left, D (0x023) for right.
  - Each physical key is tracked separately. key_held[i] = arrow_held[i] | letter_held[i].
  - key_pulse fires only on the 0->1 transition of the combined bit. Releasing one source while the other is held keeps the bit at 1.
  - S remains shoot.
- Undefined: only the arrow keys and S are mapped; 0x01D, 0x01C and 0x023 are unmapped.

Test Plan:
1. Frame 0x75 after E0 (E0 parity 0, 75 parity 0) -> scan_code=0x175, scan_break=0, scan_valid 1 cycle; key_held=5'b00001; key_pulse=5'b00001 for 1 cycle.
2. Send E0 F0 75 after test 1 -> scan_break=1, scan_code=0x175; key_held=0; no key_pulse.
3. Repeat 1B (parity 1) three times -> 3 scan_valid strobes; key_held[4]=1; key_pulse[4] high exactly once.
4. Byte 0x72 with parity forced to 0 -> frame_error 1 cycle; no scan_valid; key_held unchanged. A following valid E0 72 yields scan_code=0x172.
5. Stop after 4 data bits, idle TIMEOUT_CYCLES clocks -> frame_error exactly at timeout; FSM back in IDLE. A following full frame 0x1B decodes correctly.
6. Hold up and left, assert reset mid-frame for 1 cycle -> all outputs 0; a new frame starting 2 cycles after reset is received correctly. With KB_WASD_EN: press W and up, release up -> key_held[0] stays 1.
